// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader uses the slave modport. The byte source and the memory side use the master modport.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader for the instruction memory.
// It receives a framed little-endian byte stream: LEN_LO, LEN_HI, N words of 4 bytes, then CSUM.
// It writes each word to consecutive addresses starting at 0.
// The CPU is held in reset until a frame ends with a matching XOR checksum.
//
//  state | meaning
//  LEN0  | waiting for the low byte of the word count
//  LEN1  | waiting for the high byte; range check of the word count
//  DATA  | assembling 4-byte words and issuing one write per word
//  CSUM  | comparing the checksum byte with the running XOR
//  RUN   | load good, CPU released (terminal)
//  ERR   | overflow or checksum mismatch (terminal)
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    imem_boot_loader_if.slave bus,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   loaded_words
);

    typedef enum logic [2:0] {
        S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RUN, S_ERR
    } state_t;

    localparam logic [16:0]     CAP = 17'd1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    state_t            state_q;
    logic [7:0]        len_lo_q;
    logic [ADDR_W:0]   words_left_q;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       asm_q;
    logic [7:0]        xor_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   loaded_q;
    logic              cpu_rst_q;
    logic              done_q;
    logic              error_q;

    logic              xfer;
    logic [15:0]       len_w;

    assign bus.in_ready   = (state_q != S_RUN) && (state_q != S_ERR);
    assign xfer           = bus.in_valid && bus.in_ready;
    assign len_w          = {bus.in_data, len_lo_q};

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_rst        = cpu_rst_q;
    assign done           = done_q;
    assign error          = error_q;
    assign loaded_words   = loaded_q;

    // Frame FSM. It also assembles words and drives the registered write strobe and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LEN0;
            len_lo_q     <= 8'd0;
            words_left_q <= '0;
            byte_cnt_q   <= 2'd0;
            asm_q        <= 24'd0;
            xor_q        <= 8'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            loaded_q     <= '0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (xfer) begin
                unique case (state_q)
                    S_LEN0: begin
                        xor_q    <= xor_q ^ bus.in_data;
                        len_lo_q <= bus.in_data;
                        state_q  <= S_LEN1;
                    end
                    S_LEN1: begin
                        xor_q <= xor_q ^ bus.in_data;
                        if ({1'b0, len_w} > CAP) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end else if (len_w == 16'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            words_left_q <= len_w[ADDR_W:0];
                            state_q      <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        xor_q      <= xor_q ^ bus.in_data;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            // The finished word goes to its own register, so the assembler can take the next byte at once.
                            wdata_q      <= {bus.in_data, asm_q};
                            addr_q       <= loaded_q[ADDR_W-1:0];
                            we_q         <= 1'b1;
                            loaded_q     <= loaded_q + ONE;
                            words_left_q <= words_left_q - ONE;
                            if (words_left_q == ONE) begin
                                state_q <= S_CSUM;
                            end
                        end else begin
                            asm_q <= {bus.in_data, asm_q[23:8]};
                        end
                    end
                    S_CSUM: begin
                        if (bus.in_data == xor_q) begin
                            state_q   <= S_RUN;
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;
    localparam int ADDR_W = 8;
    localparam int CAP    = 1 << ADDR_W;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int unsigned cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic cpu_rst, done, error;
    logic [ADDR_W:0] loaded_words;

    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error),
        .loaded_words (loaded_words)
    );

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    wr_t         obs_q[$];
    wr_t         exp_q[$];
    int unsigned acc_q[$];
    logic [7:0]  frm[$];
    bit          exp_done, exp_err;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_t w;
            w.addr = int'(bus.imem_addr);
            w.data = bus.imem_wdata;
            w.cyc  = cyc;
            obs_q.push_back(w);
        end
    end

    // Drive one cycle of stimulus; called and returns just after a falling edge.
    task automatic drive(input logic v, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 8'h00);
        rst = 1'b0;
        obs_q.delete();
    endtask

    task automatic set_nominal(input logic [7:0] last);
        frm = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, last};
    endtask

    // Send frm. For every 4th data byte, note the cycle in which its write is due.
    task automatic send_frame(input bit gaps);
        int n;
        n = int'({frm[1], frm[0]});
        acc_q.delete();
        for (int i = 0; i < frm.size(); i++) begin
            int j;
            if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 8'($urandom));
            j = i - 2;
            if (n <= CAP && j >= 0 && j < 4 * n && (j % 4) == 3) acc_q.push_back(cyc + 1);
            drive(1'b1, frm[i]);
        end
        drive(1'b0, 8'h00);
    endtask

    // Reference model: decode the frame directly from its byte layout.
    task automatic build_expect();
        int n;
        logic [7:0] x;
        wr_t w;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n = int'({frm[1], frm[0]});
        if (n > CAP) begin
            exp_err = 1'b1;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * n; i++) x ^= frm[i];
        for (int k = 0; k < n; k++) begin
            w.addr = k;
            w.data = {frm[2+4*k+3], frm[2+4*k+2], frm[2+4*k+1], frm[2+4*k]};
            w.cyc  = acc_q[k];
            exp_q.push_back(w);
        end
        if (frm[2+4*n] == x) exp_done = 1'b1;
        else exp_err = 1'b1;
    endtask

    task automatic test_frame(input string name, input bit gaps);
        int ncmp;
        send_frame(gaps);
        repeat (2) drive(1'b0, 8'h00);
        build_expect();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
        end
        ncmp = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < ncmp; i++) begin
            checks++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data ||
                obs_q[i].cyc !== exp_q[i].cyc) begin
                errors++;
                $display("FAIL %s write[%0d]: got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                         name, i, obs_q[i].addr, obs_q[i].data, obs_q[i].cyc,
                         exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
            end
        end
        checks++;
        if (done !== exp_done || error !== exp_err || cpu_rst !== !exp_done ||
            bus.in_ready !== 1'b0 || loaded_words !== (ADDR_W+1)'(exp_q.size())) begin
            errors++;
            $display("FAIL %s status: got done=%b error=%b cpu_rst=%b in_ready=%b loaded=%0d expected %b %b %b 0 %0d",
                     name, done, error, cpu_rst, bus.in_ready, loaded_words,
                     exp_done, exp_err, !exp_done, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.imem_we !== 1'b0 || bus.imem_addr !== '0 ||
            bus.imem_wdata !== 32'd0 || cpu_rst !== 1'b1 || done !== 1'b0 ||
            error !== 1'b0 || loaded_words !== '0) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b we=%b addr=%0d wd=%h cpu_rst=%b done=%b err=%b loaded=%0d",
                     bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, cpu_rst, done, error, loaded_words);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        set_nominal(8'hC3);
        test_frame("nominal", 1'b0);
        checks++;
        if (obs_q.size() != 2 || obs_q[0].data !== 32'h00500093 || obs_q[1].data !== 32'h00100113) begin
            errors++;
            $display("FAIL nominal_words: got %0d writes, expected 00500093 and 00100113", obs_q.size());
        end
    endtask

    task automatic test_post_done();
        logic [ADDR_W:0] lw;
        logic [31:0] wd;
        int nw;
        lw = loaded_words;
        wd = bus.imem_wdata;
        nw = obs_q.size();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL post_done_ready: got %b expected 0", bus.in_ready);
            end
            drive(1'b1, 8'($urandom));
        end
        drive(1'b0, 8'h00);
        checks++;
        if (obs_q.size() != nw || loaded_words !== lw || bus.imem_wdata !== wd ||
            done !== 1'b1 || error !== 1'b0 || cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL post_done_outputs: got writes=%0d loaded=%0d done=%b err=%b cpu_rst=%b expected %0d %0d 1 0 0",
                     obs_q.size(), loaded_words, done, error, cpu_rst, nw, lw);
        end
    endtask

    task automatic test_bad_csum();
        do_reset();
        set_nominal(8'hC2);
        test_frame("bad_csum", 1'b0);
    endtask

    task automatic test_overflow();
        do_reset();
        drive(1'b1, 8'h01);
        drive(1'b1, 8'h01);
        checks++;
        if (error !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL overflow_immediate: got error=%b in_ready=%b expected 1 0", error, bus.in_ready);
        end
        for (int i = 0; i < 12; i++) drive(1'b1, 8'($urandom));
        drive(1'b0, 8'h00);
        checks++;
        if (obs_q.size() != 0 || loaded_words !== '0 || cpu_rst !== 1'b1 || done !== 1'b0 || error !== 1'b1) begin
            errors++;
            $display("FAIL overflow_after: got writes=%0d loaded=%0d cpu_rst=%b done=%b err=%b expected 0 0 1 0 1",
                     obs_q.size(), loaded_words, cpu_rst, done, error);
        end
    endtask

    task automatic test_empty();
        do_reset();
        frm = '{8'h00, 8'h00, 8'h00};
        test_frame("empty", 1'b0);
    endtask

    task automatic test_gaps();
        do_reset();
        set_nominal(8'hC3);
        test_frame("nominal_gaps", 1'b1);
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        drive(1'b1, 8'h02);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h93);
        drive(1'b1, 8'h00);
        rst = 1'b1;
        drive(1'b0, 8'h00);
        rst = 1'b0;
        set_nominal(8'hC3);
        test_frame("reset_mid_word", 1'b0);
    endtask

    task automatic test_max_len();
        logic [7:0] x;
        do_reset();
        frm = '{8'h00, 8'h01};
        for (int i = 0; i < 4 * CAP; i++) frm.push_back(8'($urandom));
        x = 8'h00;
        foreach (frm[i]) x ^= frm[i];
        frm.push_back(x);
        test_frame("max_len", 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int n;
            logic [7:0] x;
            do_reset();
            n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 7));
            frm = '{8'(n), 8'h00};
            for (int i = 0; i < 4 * n; i++) frm.push_back(8'($urandom));
            x = 8'h00;
            foreach (frm[i]) x ^= frm[i];
            if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
            frm.push_back(x);
            test_frame($sformatf("random_%0d", it), bit'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_post_done();
        test_bad_csum();
        test_overflow();
        test_empty();
        test_gaps();
        test_reset_mid_word();
        test_max_len();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
